mips_cpu_divider: RTL and testbench

MIPS_CPU_DIVIDER -- requirements
Module: mips_cpu_divider

---
 rtl/mips_cpu_divider.sv | 182 ++++++++++++++++++
 tb/tb_mips_cpu_divider.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_divider.sv
// -----------------------------------------------------------------------------
// mips_cpu_divider
//
// Multi-cycle MIPS DIV/DIVU unit. It uses a restoring shift-subtract
// algorithm that produces one quotient bit per enabled clock.
//
// Sequence, counting the accepting edge as edge 1:
//   edge 1      IDLE -> BUSY.  Operand magnitudes, sign flags and the raw
//               dividend are captured, and the step counter is cleared.
//   edges 2-33  BUSY.  32 restoring steps are performed; the last one
//               moves the FSM to FIX.
//   edge 34     FIX -> DONE.  Sign corrections are applied and hi/lo are
//               written.
//   done is high for the cycle after edge 34.  The FSM then returns to IDLE.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   clk_enable   1 = state may advance, 0 = all state frozen
//   start        divide request, honoured only in IDLE with clk_enable high
//   is_signed    1 = DIV (two's complement), 0 = DIVU
//   dividend     rs operand, captured on the accepting edge
//   divisor      rt operand, captured on the accepting edge
//   busy         high while an operation is in flight (BUSY/FIX/DONE)
//   done         one-cycle pulse when hi/lo hold a fresh result
//   hi           remainder (registered, held until the next result)
//   lo           quotient  (registered, held until the next result)
//   div_by_zero  optional; present only when DIV_ZERO_FLAG_EN is defined.
//                It is registered together with hi/lo.
//
// Configuration macro: DIV_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
module mips_cpu_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic        div_by_zero
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [31:0] rem_reg;        // partial remainder
  logic [31:0] quot_reg;       // dividend bits shift out, quotient bits shift in
  logic [31:0] dvsr_reg;       // divisor magnitude
  logic [31:0] dvnd_raw_reg;   // unmodified dividend, returned on divide-by-zero
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        dvsr_zero_reg;
  logic [31:0] hi_reg, lo_reg;

  logic        accept;
  logic        dividend_neg, divisor_neg;
  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] shifted;
  logic [32:0] trial_sub;
  logic [31:0] quot_fixed, rem_fixed;

  assign accept = clk_enable && start && (state_reg == IDLE);

  // The magnitudes wrap in 32 bits, so |0x80000000| stays 0x80000000.
  // Treated as unsigned, this is still the correct magnitude.
  assign dividend_neg = is_signed & dividend[31];
  assign divisor_neg  = is_signed & divisor[31];
  assign dividend_mag = dividend_neg ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = divisor_neg  ? (~divisor  + 32'd1) : divisor;

  // Restoring step.  The partial remainder is always smaller than the
  // divisor, so the shifted value minus the divisor is non-negative exactly
  // when bit 32 of the 33-bit difference is clear.
  assign shifted   = {rem_reg, quot_reg[31]};
  assign trial_sub = shifted - {1'b0, dvsr_reg};

  assign quot_fixed = neg_q_reg ? (~quot_reg + 32'd1) : quot_reg;
  assign rem_fixed  = neg_r_reg ? (~rem_reg  + 32'd1) : rem_reg;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clk_enable) begin
      case (state_reg)
        IDLE:    if (start) state_next = BUSY;
        BUSY:    if (cnt_reg == 5'd31) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= 5'd0;
      rem_reg       <= 32'd0;
      quot_reg      <= 32'd0;
      dvsr_reg      <= 32'd0;
      dvnd_raw_reg  <= 32'd0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dvsr_zero_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg       <= 5'd0;
      rem_reg       <= 32'd0;
      quot_reg      <= dividend_mag;
      dvsr_reg      <= divisor_mag;
      dvnd_raw_reg  <= dividend;
      neg_q_reg     <= dividend_neg ^ divisor_neg;
      neg_r_reg     <= dividend_neg;
      dvsr_zero_reg <= (divisor == 32'd0);
    end else if (clk_enable && state_reg == BUSY) begin
      cnt_reg <= cnt_reg + 5'd1;
      if (!trial_sub[32]) begin
        rem_reg  <= trial_sub[31:0];
        quot_reg <= {quot_reg[30:0], 1'b1};
      end else begin
        rem_reg  <= shifted[31:0];
        quot_reg <= {quot_reg[30:0], 1'b0};
      end
    end
  end

  // The result registers are written only on the FIX -> DONE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (clk_enable && state_reg == FIX) begin
      if (dvsr_zero_reg) begin
        hi_reg <= dvnd_raw_reg;
        lo_reg <= 32'hFFFF_FFFF;
      end else begin
        hi_reg <= rem_fixed;
        lo_reg <= quot_fixed;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic div_by_zero_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_by_zero_reg <= 1'b0;
    end else if (clk_enable && state_reg == FIX) begin
      div_by_zero_reg <= dvsr_zero_reg;
    end
  end

  assign div_by_zero = div_by_zero_reg;
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_divider
//
// Testbench for mips_cpu_divider.  It applies a table of directed divide
// vectors with hand-computed results.  Hand-written sequences then cover:
//   - a clk_enable stall,
//   - a start ignored while busy,
//   - operand changes after acceptance,
//   - a reset that aborts an operation in flight.
//
// Latency is counted in rising edges, including the accepting edge.  done
// must be seen after edge 34.
// -----------------------------------------------------------------------------
module tb_mips_cpu_divider;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_by_zero;
`endif

  mips_cpu_divider dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
    string       name;
  } vec_t;

  vec_t vecs[12];

  int passed;
  int total;
  int edges;
  bit got_done;
  int done_pulses;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Present the operands and start, then let the accepting edge pass.
  // After acceptance the operand inputs are scrambled.  This shows that
  // only the captured values are used.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~s;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Advance one edge at a time, sampling on the falling edge, until done
  // is seen.  The number of edges waited is bounded.
  task automatic wait_done();
    got_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    edges      = 0;
    reset      = 1'b0;
    clk_enable = 1'b1;
    start      = 1'b0;
    is_signed  = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;

    vecs[0]  = '{1'b0, 32'h0000_003E, 32'h0000_0005, 32'h0000_000C, 32'h0000_0002, 1'b0, "divu_62_5"};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "div_m7_2"};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, "div_overflow"};
    vecs[3]  = '{1'b0, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1, "divu_100_0"};
    vecs[4]  = '{1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0003, 32'h0000_0001, 1'b0, "divu_10_3"};
    vecs[5]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, "div_7_m2"};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, "div_m7_m2"};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "divu_max_1"};
    vecs[8]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0, "divu_big_2"};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, "div_m100_0"};
    vecs[10] = '{1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0005, 1'b0, "divu_5_7"};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0, "div_min_1"};

    // ---- reset state ----------------------------------------------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_dz", {31'd0, div_by_zero}, 32'd0);
`endif
    reset = 1'b1;

    // ---- table-driven vectors -------------------------------------------
    for (int v = 0; v < 12; v++) begin
      start_op(vecs[v].s, vecs[v].a, vecs[v].b);
      check({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done();
      check({vecs[v].name, "_done_seen"}, {31'd0, got_done}, 32'd1);
      check({vecs[v].name, "_latency"}, edges, 32'd34);
      check({vecs[v].name, "_lo"}, lo, vecs[v].exp_lo);
      check({vecs[v].name, "_hi"}, hi, vecs[v].exp_hi);
`ifdef DIV_ZERO_FLAG_EN
      check({vecs[v].name, "_dz"}, {31'd0, div_by_zero}, {31'd0, vecs[v].exp_dz});
`endif
      $display("op %-12s s=%0d a=%h b=%h -> lo=%h hi=%h edges=%0d",
               vecs[v].name, vecs[v].s, vecs[v].a, vecs[v].b, lo, hi, edges);
      @(posedge clk);
      @(negedge clk);
      check({vecs[v].name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end

    // ---- stall, ignored start, held results ---------------------------------
    start_op(1'b0, 32'd62, 32'd5);
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin
        // A second request while busy must be dropped, not queued.
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_lo_midbusy", lo, 32'h8000_0000);
    check("hold_hi_midbusy", hi, 32'h0000_0000);
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("stall_busy", {31'd0, busy}, 32'd1);
    clk_enable = 1'b1;
    wait_done();
    check("stall_done_seen", {31'd0, got_done}, 32'd1);
    check("stall_latency", edges, 32'd39);
    check("stall_lo", lo, 32'h0000_000C);
    check("stall_hi", hi, 32'h0000_0002);
    $display("op stall_62_5  lo=%h hi=%h edges=%0d", lo, hi, edges);
    // done must persist while the clock enable is low
    clk_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_held_frozen", {31'd0, done}, 32'd1);
    clk_enable = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_pulses++;
    end
    check("ignored_start_pulses", done_pulses, 32'd0);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);

    // ---- reset mid-operation ----------------------------------------------
    start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    // Queue the next request while reset is held.  It must be accepted
    // on the first edge after release.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd62;
    divisor   = 32'd5;
    start     = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_pulses++;
    end
    check("abort_no_done", done_pulses, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd0;
    check("post_reset_accept", {31'd0, busy}, 32'd1);
    wait_done();
    check("post_reset_done_seen", {31'd0, got_done}, 32'd1);
    check("post_reset_latency", edges, 32'd34);
    check("post_reset_lo", lo, 32'h0000_000C);
    check("post_reset_hi", hi, 32'h0000_0002);
    $display("op post_reset  lo=%h hi=%h edges=%0d", lo, hi, edges);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
